// File: rtl/serial_adder_ctrl_if.sv
// Handshake and data bundle for the bit-serial adder controller.
// The master side issues start/operands; the slave side returns status and result.
interface serial_adder_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one 1-bit full adder sequenced over WIDTH cycles.
// Operands are captured on the accepting edge and shifted out LSB first;
// the partial sum fills from the MSB so the LSB lands at bit 0 after WIDTH shifts.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_adder_ctrl_if.slave bus
);
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] psum;
  logic [WIDTH-1:0] sum_q;
  logic             carry;
  logic             cout_q;
  logic             busy_q;
  logic             done_q;
  logic [CW-1:0]    cnt;

  logic load;
  logic step;
  logic last;
  logic fa_sum;
  logic fa_cout;

  full_adder u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and datapath control strobes
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    last       = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          load       = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        step = 1'b1;
        if (cnt == CNT_LAST) begin
          last       = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand shift registers, carry, partial sum and bit counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr  <= '0;
      b_sr  <= '0;
      psum  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else if (load) begin
      a_sr  <= bus.a;
      b_sr  <= bus.b;
      psum  <= '0;
      carry <= bus.cin;
      cnt   <= '0;
    end else if (step) begin
      a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
      psum  <= {fa_sum, psum[WIDTH-1:1]};
      carry <= fa_cout;
      // Return to zero on the final shift so cnt never passes WIDTH-1
      // for widths that are not a power of two.
      cnt   <= last ? '0 : cnt + CW'(1);
    end
  end

  // Result registers: updated only on the edge entering DONE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else if (last) begin
      sum_q  <= {fa_sum, psum[WIDTH-1:1]};
      cout_q <= fa_cout;
    end
  end

  // Registered status flags derived from the upcoming state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= (state_next != IDLE);
      done_q <= (state_next == DONE);
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl at WIDTH=8 and WIDTH=2.
module tb_serial_adder_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_adder_ctrl_if #(.WIDTH(8)) if8 ();
  serial_adder_ctrl_if #(.WIDTH(2)) if2 ();

  serial_adder_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
  serial_adder_ctrl #(.WIDTH(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

  int tests = 0;
  int fails = 0;

  logic [8:0] q8[$];
  logic [2:0] q2[$];
  logic prev_done8 = 1'b0;
  logic prev_done2 = 1'b0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard for the 8-bit instance
  always @(negedge clk) begin
    logic [8:0] e;
    if (if8.done) begin
      if (q8.size() == 0) begin
        check("sb8_unexpected_done", 32'd1, 32'd0);
      end else begin
        e = q8.pop_front();
        check("sb8_result", 32'({if8.cout, if8.sum}), 32'(e));
      end
      check("done8_back_to_back", 32'(prev_done8), 32'd0);
    end
    prev_done8 = if8.done;
  end

  // Scoreboard for the 2-bit instance
  always @(negedge clk) begin
    logic [2:0] e;
    if (if2.done) begin
      if (q2.size() == 0) begin
        check("sb2_unexpected_done", 32'd1, 32'd0);
      end else begin
        e = q2.pop_front();
        check("sb2_result", 32'({if2.cout, if2.sum}), 32'(e));
      end
      check("done2_back_to_back", 32'(prev_done2), 32'd0);
    end
    prev_done2 = if2.done;
  end

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                      input logic [7:0] es, input logic ec);
    int lat;
    int busy_n;
    if8.a = a; if8.b = b; if8.cin = cin; if8.start = 1'b1;
    q8.push_back({1'b0, a} + {1'b0, b} + {8'd0, cin});
    tick();
    // Scramble inputs after acceptance; the result must not follow them.
    if8.start = 1'b0; if8.a = ~a; if8.b = ~b; if8.cin = ~cin;
    busy_n = if8.busy ? 1 : 0;
    lat = 0;
    while (!if8.done && lat < 40) begin
      tick();
      lat++;
      if (if8.busy) busy_n++;
    end
    check("lat8", 32'(lat), 32'd8);
    check("sum8", 32'(if8.sum), 32'(es));
    check("cout8", 32'(if8.cout), 32'(ec));
    tick();
    check("busy8_after_done", 32'(if8.busy), 32'd0);
    check("done8_after_done", 32'(if8.done), 32'd0);
    check("busy8_cycles", 32'(busy_n), 32'd9);
  endtask

  task automatic run2(input logic [1:0] a, input logic [1:0] b, input logic cin);
    int lat;
    if2.a = a; if2.b = b; if2.cin = cin; if2.start = 1'b1;
    q2.push_back({1'b0, a} + {1'b0, b} + {2'd0, cin});
    tick();
    if2.start = 1'b0; if2.a = ~a; if2.b = ~b;
    lat = 0;
    while (!if2.done && lat < 20) begin
      tick();
      lat++;
    end
    check("lat2", 32'(lat), 32'd2);
    tick();
  endtask

  initial begin
    int rem;
    int last_done;
    int drain;
    logic [7:0] ra, rb;
    logic       rc;

    tbl[0] = '{a: 8'h35, b: 8'h4A, cin: 1'b0, sum: 8'h7F, cout: 1'b0};
    tbl[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, sum: 8'h00, cout: 1'b1};
    tbl[2] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, sum: 8'hFF, cout: 1'b1};
    tbl[3] = '{a: 8'h00, b: 8'h00, cin: 1'b0, sum: 8'h00, cout: 1'b0};
    tbl[4] = '{a: 8'h80, b: 8'h80, cin: 1'b0, sum: 8'h00, cout: 1'b1};
    tbl[5] = '{a: 8'h7F, b: 8'h01, cin: 1'b1, sum: 8'h81, cout: 1'b0};
    tbl[6] = '{a: 8'hAA, b: 8'h55, cin: 1'b1, sum: 8'h00, cout: 1'b1};

    if8.start = 1'b0; if8.a = '0; if8.b = '0; if8.cin = 1'b0;
    if2.start = 1'b0; if2.a = '0; if2.b = '0; if2.cin = 1'b0;
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    check("rst_busy8", 32'(if8.busy), 32'd0);
    check("rst_done8", 32'(if8.done), 32'd0);
    check("rst_sum8", 32'(if8.sum), 32'd0);
    check("rst_cout8", 32'(if8.cout), 32'd0);
    check("rst_sum2", 32'({if2.cout, if2.sum}), 32'd0);
    tick();

    // Table-driven vectors
    for (int i = 0; i < 7; i++) begin
      run8(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sum, tbl[i].cout);
    end

    // Reset in the third SHIFT cycle discards the operation
    if8.a = 8'h0F; if8.b = 8'hF0; if8.cin = 1'b0; if8.start = 1'b1;
    tick();
    if8.start = 1'b0;
    tick(); tick();
    check("mid_busy", 32'(if8.busy), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    q8.delete();
    check("mid_rst_busy", 32'(if8.busy), 32'd0);
    check("mid_rst_done", 32'(if8.done), 32'd0);
    check("mid_rst_sum", 32'(if8.sum), 32'd0);
    check("mid_rst_cout", 32'(if8.cout), 32'd0);
    run8(8'h01, 8'h02, 1'b0, 8'h03, 1'b0);

    // Result held while idle
    run8(8'h10, 8'h20, 1'b0, 8'h30, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("hold_sum", 32'(if8.sum), 32'h30);
      check("hold_done", 32'(if8.done), 32'd0);
    end

    // start held high, operands changing every cycle
    rem = 0;
    last_done = -1;
    if8.start = 1'b1;
    for (int k = 0; k < 45; k++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      if8.a = ra; if8.b = rb; if8.cin = rc;
      if (rem == 0) begin
        q8.push_back({1'b0, ra} + {1'b0, rb} + {8'd0, rc});
        rem = 9;
      end else begin
        rem--;
      end
      tick();
      if (if8.done) begin
        if (last_done >= 0) check("done_spacing", 32'(k - last_done), 32'd10);
        last_done = k;
      end
    end
    if8.start = 1'b0;
    drain = 0;
    while (q8.size() != 0 && drain < 30) begin
      tick();
      drain++;
    end
    check("drain8", 32'(q8.size()), 32'd0);
    tick();

    // WIDTH=2 exhaustive
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        for (int c = 0; c < 2; c++)
          run2(2'(a), 2'(b), 1'(c));
    check("drain2", 32'(q2.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
